rx_pkt_ctrl: RTL and testbench

//  USB packet receive controller; the receive-side counterpart of the packet transmit sequencer.

---
 rtl/rx_pkt_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rx_pkt_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pkt_ctrl.sv
// USB packet receiver: SYNC/PID check, token or payload capture, CRC16 check (CRC16_CHECK_EN), EOP required.
// Latency: the *_ready strobe is registered and is high in the cycle after the eop cycle.
// Backpressure: none; each byte_ready/eop strobe is consumed in the cycle it arrives, and eop beats byte_ready.
module rx_pkt_ctrl #(
    parameter int         DATA_BYTES = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'h80
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    d_edge,
    input  logic                    byte_ready,
    input  logic [7:0]              rcv_byte,
    input  logic                    eop,
    output logic                    rcving,
    output logic [3:0]              rcv_pid,
    output logic [15:0]             rcv_token,
    output logic [DATA_BYTES*8-1:0] rcv_data,
    output logic                    token_ready,
    output logic                    data_ready,
    output logic                    hs_ready,
    output logic                    rcv_error
);

    localparam int W  = DATA_BYTES * 8;
    localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, TOKEN, DATA, CRC, EOP_WAIT, ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] byte_cnt;
    logic          tok_cnt;
    logic          crc_cnt;

`ifdef CRC16_CHECK_EN
    logic [15:0] crc_reg;
    logic [7:0]  crc_lo;
    logic        crc_ok;

    // Reflected CRC-16 (poly 0xA001) advanced by one byte, LSB of the byte first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction
`endif

    // Packet sequencer: state, captured fields, registered strobes and sticky error.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            tok_cnt     <= 1'b0;
            crc_cnt     <= 1'b0;
            rcving      <= 1'b0;
            rcv_pid     <= 4'h0;
            rcv_token   <= 16'h0000;
            rcv_data    <= '0;
            token_ready <= 1'b0;
            data_ready  <= 1'b0;
            hs_ready    <= 1'b0;
            rcv_error   <= 1'b0;
`ifdef CRC16_CHECK_EN
            crc_reg     <= 16'hFFFF;
            crc_lo      <= 8'h00;
            crc_ok      <= 1'b0;
`endif
        end else begin
            token_ready <= 1'b0;
            data_ready  <= 1'b0;
            hs_ready    <= 1'b0;

            if (state == IDLE) begin
                if (d_edge) begin
                    state     <= SYNC;
                    rcving    <= 1'b1;
                    rcv_error <= 1'b0;
                end
            end else if (eop) begin
                // eop always ends the packet; only a clean EOP_WAIT exit reports it
                state  <= IDLE;
                rcving <= 1'b0;
                if (state == EOP_WAIT) begin
                    case (rcv_pid[1:0])
                        2'b01:   token_ready <= 1'b1;
                        2'b10:   hs_ready    <= 1'b1;
`ifdef CRC16_CHECK_EN
                        2'b11: begin
                            if (crc_ok) data_ready <= 1'b1;
                            else        rcv_error  <= 1'b1;
                        end
`else
                        2'b11:   data_ready  <= 1'b1;
`endif
                        default: rcv_error   <= 1'b1;
                    endcase
                end else begin
                    rcv_error <= 1'b1;
                end
            end else if (byte_ready) begin
                case (state)
                    SYNC: begin
                        if (rcv_byte == SYNC_BYTE) begin
                            state <= PID;
                        end else begin
                            state     <= ERR;
                            rcv_error <= 1'b1;
                        end
                    end
                    PID: begin
                        if (rcv_byte[7:4] != ~rcv_byte[3:0] || rcv_byte[1:0] == 2'b00) begin
                            // check bits broken, or a special PID this receiver does not handle
                            state     <= ERR;
                            rcv_error <= 1'b1;
                            if (rcv_byte[7:4] == ~rcv_byte[3:0]) rcv_pid <= rcv_byte[3:0];
                        end else begin
                            rcv_pid <= rcv_byte[3:0];
                            case (rcv_byte[1:0])
                                2'b01: begin
                                    state   <= TOKEN;
                                    tok_cnt <= 1'b0;
                                end
                                2'b11: begin
                                    state    <= DATA;
                                    byte_cnt <= '0;
`ifdef CRC16_CHECK_EN
                                    crc_reg  <= 16'hFFFF;
`endif
                                end
                                default: state <= EOP_WAIT;
                            endcase
                        end
                    end
                    TOKEN: begin
                        if (!tok_cnt) begin
                            rcv_token[7:0] <= rcv_byte;
                            tok_cnt        <= 1'b1;
                        end else begin
                            rcv_token[15:8] <= rcv_byte;
                            state           <= EOP_WAIT;
                        end
                    end
                    DATA: begin
                        rcv_data <= {rcv_byte, rcv_data[W-1:8]};
`ifdef CRC16_CHECK_EN
                        crc_reg  <= crc16_byte(crc_reg, rcv_byte);
`endif
                        if (byte_cnt == CW'(DATA_BYTES - 1)) begin
                            state   <= CRC;
                            crc_cnt <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                    CRC: begin
                        if (!crc_cnt) begin
                            crc_cnt <= 1'b1;
`ifdef CRC16_CHECK_EN
                            crc_lo  <= rcv_byte;
`endif
                        end else begin
                            state  <= EOP_WAIT;
`ifdef CRC16_CHECK_EN
                            crc_ok <= ({rcv_byte, crc_lo} == ~crc_reg);
`endif
                        end
                    end
                    EOP_WAIT: begin
                        state     <= ERR;
                        rcv_error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Scoreboard bench for rx_pkt_ctrl (DATA_BYTES=8); CRC16_CHECK_EN selects bad-CRC expectations.
// Latency: expects each strobe in the cycle after eop, exactly one cycle wide.
// Backpressure: none; bytes are driven as back-to-back one-cycle strobes.
module tb_rx_pkt_ctrl;

    localparam logic [2:0] K_TOK  = 3'b100;
    localparam logic [2:0] K_DATA = 3'b010;
    localparam logic [2:0] K_HS   = 3'b001;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        d_edge;
    logic        byte_ready;
    logic [7:0]  rcv_byte;
    logic        eop;
    logic        rcving;
    logic [3:0]  rcv_pid;
    logic [15:0] rcv_token;
    logic [63:0] rcv_data;
    logic        token_ready;
    logic        data_ready;
    logic        hs_ready;
    logic        rcv_error;

    typedef struct {
        logic [2:0]  kind;
        logic [3:0]  pid;
        logic [15:0] tok;
        logic [63:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [2:0] prev_k = 3'b000;

    rx_pkt_ctrl dut (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_ready(byte_ready),
        .rcv_byte(rcv_byte), .eop(eop), .rcving(rcving), .rcv_pid(rcv_pid),
        .rcv_token(rcv_token), .rcv_data(rcv_data), .token_ready(token_ready),
        .data_ready(data_ready), .hs_ready(hs_ready), .rcv_error(rcv_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // bit-serial reference CRC, LSB of each byte first
    function automatic logic [15:0] crc_model(input logic [63:0] payload);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int n = 0; n < 8; n++) begin
            b = payload[n*8 +: 8];
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
                else             c = c >> 1;
            end
        end
        return c;
    endfunction

    // Monitor: every strobe must match the oldest expected packet.
    always @(negedge clk) begin
        logic [2:0] k;
        exp_t e;
        k = {token_ready, data_ready, hs_ready};
        if (n_rst && k != 3'b000) begin
            check_val("pulse_width", {61'd0, prev_k}, 64'd0);
            check_val("strobe_expected", {63'd0, sb_q.size() != 0}, 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_val("strobe_kind", {61'd0, k}, {61'd0, e.kind});
                check_val("pid", {60'd0, rcv_pid}, {60'd0, e.pid});
                check_val("err_on_strobe", {63'd0, rcv_error}, 64'd0);
                check_val("rcving_on_strobe", {63'd0, rcving}, 64'd0);
                if (e.kind == K_TOK)  check_val("token", {48'd0, rcv_token}, {48'd0, e.tok});
                if (e.kind == K_DATA) check_val("data", rcv_data, e.dat);
            end
        end
        prev_k = n_rst ? k : 3'b000;
    end

    task automatic push_exp(input logic [2:0] kind, input logic [3:0] pid,
                            input logic [15:0] tok, input logic [63:0] dat);
        exp_t e;
        e.kind = kind; e.pid = pid; e.tok = tok; e.dat = dat;
        sb_q.push_back(e);
    endtask

    task automatic start_pkt();
        d_edge = 1'b1;
        @(posedge clk); #1;
        d_edge = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rcv_byte = b;
        byte_ready = 1'b1;
        @(posedge clk); #1;
        byte_ready = 1'b0;
    endtask

    task automatic send_eop(input logic with_byte);
        eop = 1'b1;
        byte_ready = with_byte;
        @(posedge clk); #1;
        eop = 1'b0;
        byte_ready = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, sb_q.size(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic expect_err(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_err"}, {63'd0, rcv_error}, 64'd1);
        check_val({tag, "_rcving"}, {63'd0, rcving}, 64'd0);
        check_val({tag, "_nostrobe"}, sb_q.size(), 64'd0);
    endtask

    task automatic send_data_pkt(input logic [7:0] pid_byte, input logic [63:0] payload,
                                 input logic corrupt);
        logic [15:0] tx;
        tx = ~crc_model(payload);
        if (corrupt) tx[0] = ~tx[0];
        start_pkt();
        send_byte(8'h80);
        send_byte(pid_byte);
        for (int i = 0; i < 8; i++) send_byte(payload[i*8 +: 8]);
        send_byte(tx[7:0]);
        send_byte(tx[15:8]);
`ifdef CRC16_CHECK_EN
        if (!corrupt) push_exp(K_DATA, pid_byte[3:0], 16'h0, payload);
`else
        push_exp(K_DATA, pid_byte[3:0], 16'h0, payload);
`endif
        send_eop(1'b0);
    endtask

    task automatic send_hs();
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hD2);
        push_exp(K_HS, 4'h2, 16'h0, 64'h0);
        send_eop(1'b0);
        wait_drain("hs_drain");
    endtask

    initial begin
        logic [63:0] rnd;
        n_rst = 1'b0; d_edge = 1'b0; byte_ready = 1'b0; rcv_byte = 8'h00; eop = 1'b0;
        #3;
        check_val("rst_rcving", {63'd0, rcving}, 64'd0);
        check_val("rst_pid", {60'd0, rcv_pid}, 64'd0);
        check_val("rst_token", {48'd0, rcv_token}, 64'd0);
        check_val("rst_data", rcv_data, 64'd0);
        check_val("rst_strobes", {61'd0, token_ready, data_ready, hs_ready}, 64'd0);
        check_val("rst_err", {63'd0, rcv_error}, 64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        // handshake
        start_pkt();
        check_val("rcving_set", {63'd0, rcving}, 64'd1);
        send_byte(8'h80);
        send_byte(8'hD2);
        push_exp(K_HS, 4'h2, 16'h0, 64'h0);
        send_eop(1'b0);
        wait_drain("hs_drain");

        // token, with a stray d_edge mid-packet that must be ignored
        start_pkt();
        send_byte(8'h80);
        d_edge = 1'b1;
        send_byte(8'hE1);
        d_edge = 1'b0;
        send_byte(8'h15);
        send_byte(8'h3A);
        push_exp(K_TOK, 4'h1, 16'h3A15, 64'h0);
        send_eop(1'b0);
        wait_drain("tok_drain");

        // data packets: counting payload then random payloads on DATA1
        send_data_pkt(8'hC3, 64'h0706050403020100, 1'b0);
        wait_drain("data0_drain");
        for (int r = 0; r < 3; r++) begin
            rnd = {$urandom, $urandom};
            send_data_pkt(8'h4B, rnd, 1'b0);
            wait_drain("data_rnd_drain");
        end

        // corrupted CRC
        send_data_pkt(8'hC3, 64'h1122334455667788, 1'b1);
`ifdef CRC16_CHECK_EN
        expect_err("bad_crc");
`else
        wait_drain("bad_crc_unchecked");
`endif

        // bad sync byte
        start_pkt();
        send_byte(8'h81);
        send_byte(8'hD2);
        send_eop(1'b0);
        expect_err("sync");

        // error clears on the next packet
        send_hs();

        // broken PID check bits
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hC2);
        send_eop(1'b0);
        expect_err("pid");

        // special PID type
        start_pkt();
        send_byte(8'h80);
        send_byte(8'h3C);
        send_eop(1'b0);
        expect_err("special_pid");

        // early eop after three payload bytes
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_eop(1'b0);
        expect_err("early_eop");

        // extra byte while waiting for eop
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hD2);
        send_byte(8'h55);
        send_eop(1'b0);
        expect_err("extra_byte");

        // byte and eop together: eop wins, packet accepted
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hD2);
        push_exp(K_HS, 4'h2, 16'h0, 64'h0);
        send_eop(1'b1);
        wait_drain("eop_wins_drain");

        // async reset mid-DATA
        start_pkt();
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'hAA);
        send_byte(8'hBB);
        n_rst = 1'b0;
        #1;
        check_val("midrst_rcving", {63'd0, rcving}, 64'd0);
        check_val("midrst_pid", {60'd0, rcv_pid}, 64'd0);
        check_val("midrst_data", rcv_data, 64'd0);
        check_val("midrst_err", {63'd0, rcv_error}, 64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        send_hs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
